// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator with a shared period counter and
// double-buffered duty/period registers.
//
// All channels compare one free-running counter against their own active
// duty value. Duty writes land in a per-channel shadow register; the shadow
// values and the requested period are copied into the active registers only
// at a period boundary, so a running period is never disturbed.
//
// Optional feature macro: PWM_CENTER_ALIGN_EN
//   undefined : edge-aligned, period length = period+1 clocks
//   defined   : center-aligned (0 -> P -> 1 -> 0 ...), period length = 2*P clocks
//
// Parameters:
//   WIDTH        counter / period / duty width in bits
//   NCH          number of PWM channels (>= 1)
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   en           run enable; low holds the counter at 0 and reloads the active regs
//   period       requested period value, loaded at the next boundary
//   duty_in      packed duty values, channel i at [i*WIDTH +: WIDTH]
//   duty_wr      per-channel write strobe into the duty shadow registers
//   PWM_sig      registered PWM outputs, one per channel
//   cycle_start  registered one-clock pulse on the first clock of each period

module pwm_multi #(
  parameter int WIDTH = 10,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     period,
  input  logic [NCH*WIDTH-1:0] duty_in,
  input  logic [NCH-1:0]       duty_wr,
  output logic [NCH-1:0]       PWM_sig,
  output logic                 cycle_start
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] period_act_q;
  logic [WIDTH-1:0] period_act_d;
  logic [WIDTH-1:0] duty_sh_q  [NCH];
  logic [WIDTH-1:0] duty_sh_d  [NCH];
  logic [WIDTH-1:0] duty_act_q [NCH];
  logic [WIDTH-1:0] duty_act_d [NCH];
  logic [NCH-1:0]   pwm_q;
  logic [NCH-1:0]   pwm_d;
  logic             cycle_start_q;
  logic             cycle_start_d;

  // High when the counter is at the top of its range (wrap cycle in edge mode).
  logic             at_top;
  // High on the edge that starts a new period (or every cycle while idle):
  // shadow duties and requested period are copied into the active registers.
  logic             load_act;

`ifdef PWM_CENTER_ALIGN_EN
  // Count direction; 1 = counting up. Only meaningful in center-aligned mode.
  logic             dir_up_q;
  logic             dir_up_d;
`endif

  assign at_top = (cnt_q == period_act_q);

  // ---------------------------------------------------------------------------
  // Period counter and boundary detection
  // ---------------------------------------------------------------------------
`ifdef PWM_CENTER_ALIGN_EN
  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    load_act = 1'b0;
    if (!en) begin
      cnt_d    = '0;
      dir_up_d = 1'b1;
      load_act = 1'b1;
    end else if (dir_up_q) begin
      if (!at_top) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (period_act_q > WIDTH'(1)) begin
        // Turn around at the top; the top value itself is visited once.
        cnt_d    = period_act_q - WIDTH'(1);
        dir_up_d = 1'b0;
      end else begin
        // period_act of 0 or 1 has no down leg: 0 holds, 1 toggles 0/1.
        cnt_d    = '0;
        load_act = 1'b1;
      end
    end else begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        // Down leg ends at 1; the next clock is cnt=0 counting up, which is
        // where the new period starts.
        cnt_d    = '0;
        dir_up_d = 1'b1;
        load_act = 1'b1;
      end
    end
  end
`else
  always_comb begin
    cnt_d    = cnt_q;
    load_act = 1'b0;
    if (!en) begin
      cnt_d    = '0;
      load_act = 1'b1;
    end else if (at_top) begin
      cnt_d    = '0;
      load_act = 1'b1;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Shadow / active registers
  // ---------------------------------------------------------------------------
  // The active copy reads the shadow's current (pre-write) value, so a write
  // coinciding with the boundary is deferred by one full period.
  always_comb begin
    period_act_d = load_act ? period : period_act_q;
    for (int i = 0; i < NCH; i++) begin
      duty_sh_d[i]  = duty_wr[i] ? duty_in[i*WIDTH +: WIDTH] : duty_sh_q[i];
      duty_act_d[i] = load_act ? duty_sh_q[i] : duty_act_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Output compare
  // ---------------------------------------------------------------------------
  // Unsigned full-width compare: duty 0 never matches (constant low) and a
  // duty above the counter's maximum always matches (constant high, no wrap
  // glitch).
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = en & (cnt_q < duty_act_q[i]);
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  assign cycle_start_d = en & (cnt_q == '0) & dir_up_q;
`else
  assign cycle_start_d = en & (cnt_q == '0);
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      period_act_q  <= '1;
      pwm_q         <= '0;
      cycle_start_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      period_act_q  <= period_act_d;
      pwm_q         <= pwm_d;
      cycle_start_q <= cycle_start_d;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_up_q <= 1'b1;
    end else begin
      dir_up_q <= dir_up_d;
    end
  end
`endif

  assign PWM_sig     = pwm_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi (default edge-aligned build).
// A reference model describes each period as "high for the first
// min(duty, period+1) clocks, cycle_start on clock 0" and pushes the expected
// output of every clock into a queue; a separate monitor pops and compares.
module tb_pwm_multi;
  localparam int W = 10;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   period = '0;
  logic [N*W-1:0] duty_in = '0;
  logic [N-1:0]   duty_wr = '0;
  logic [N-1:0]   pwm_sig;
  logic           cycle_start;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] pwm;
    logic         cs;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .NCH(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .period      (period),
    .duty_in     (duty_in),
    .duty_wr     (duty_wr),
    .PWM_sig     (pwm_sig),
    .cycle_start (cycle_start)
  );

  // ---------------- reference model ----------------
  int m_sh  [N];
  int m_duty[N];   // duties in force for the current period
  int m_per;       // length of the current period in clocks
  int m_pos;       // clock index within the current period

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    exp_t e;
    int nxt_sh[N];
    e = '0;
    for (int i = 0; i < N; i++)
      nxt_sh[i] = duty_wr[i] ? int'(duty_in[i*W +: W]) : m_sh[i];
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        nxt_sh[i] = 0;
        m_duty[i] = 0;
      end
      m_per = 1 << W;
      m_pos = 0;
    end else if (!en) begin
      m_pos = 0;
      m_per = int'(period) + 1;
      for (int i = 0; i < N; i++) m_duty[i] = m_sh[i];
    end else begin
      for (int i = 0; i < N; i++)
        e.pwm[i] = (m_pos < imin(m_duty[i], m_per));
      e.cs = (m_pos == 0);
      m_pos++;
      if (m_pos == m_per) begin
        m_pos = 0;
        m_per = int'(period) + 1;
        for (int i = 0; i < N; i++) m_duty[i] = m_sh[i];
      end
    end
    for (int i = 0; i < N; i++) m_sh[i] = nxt_sh[i];
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if ({pwm_sig, cycle_start} !== {e.pwm, e.cs}) begin
          errors++;
          $display("FAIL out_cmp at %0t: pwm=%b cs=%b, required pwm=%b cs=%b",
                   $time, pwm_sig, cycle_start, e.pwm, e.cs);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_duty(input int d0, input int d1, input logic [N-1:0] mask);
    @(negedge clk);
    duty_in = {d1[W-1:0], d0[W-1:0]};
    duty_wr = mask;
    @(negedge clk);
    duty_wr = '0;
  endtask

  // Waits for a cycle_start, then measures one period of the given length and
  // checks the high counts and that the next period starts right after.
  task automatic measure(input int len, input int hi0, input int hi1);
    int got0, got1, ncs;
    bit found;
    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(posedge clk);
      #1;
      if (cycle_start) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL measure_timeout: no cycle_start within 3000 clocks, required one");
      return;
    end
    got0 = pwm_sig[0];
    got1 = pwm_sig[1];
    ncs = 1;
    for (int k = 1; k < len; k++) begin
      @(posedge clk);
      #1;
      got0 += pwm_sig[0];
      got1 += pwm_sig[1];
      ncs  += cycle_start;
    end
    @(posedge clk);
    #1;
    checks += 4;
    if (got0 != hi0) begin
      errors++;
      $display("FAIL high_count_ch0: got %0d, required %0d", got0, hi0);
    end
    if (got1 != hi1) begin
      errors++;
      $display("FAIL high_count_ch1: got %0d, required %0d", got1, hi1);
    end
    if (ncs != 1) begin
      errors++;
      $display("FAIL cs_per_period: got %0d, required 1", ncs);
    end
    if (cycle_start !== 1'b1) begin
      errors++;
      $display("FAIL period_length: cs after %0d clocks=%b, required 1", len, cycle_start);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset held with live inputs: outputs must stay low.
    rst_n   = 1'b0;
    en      = 1'b1;
    period  = 10'd9;
    duty_in = {10'd7, 10'd3};
    duty_wr = 2'b11;
    repeat (5) @(negedge clk);
    duty_wr = '0;
    rst_n   = 1'b1;
    repeat (20) @(negedge clk);

    // Basic 3/7 of 10.
    en = 1'b0;
    write_duty(3, 7, 2'b11);
    repeat (2) @(negedge clk);
    en = 1'b1;
    measure(10, 3, 7);
    repeat (20) @(negedge clk);

    // Mid-period write 3 -> 8 on channel 0: next period only.
    measure(10, 3, 7);
    repeat (3) @(negedge clk);
    write_duty(8, 7, 2'b01);
    measure(10, 8, 7);

    // Boundaries: duty 0 and duty > period.
    repeat (3) @(negedge clk);
    write_duty(0, 10, 2'b11);
    measure(10, 0, 10);
    measure(10, 0, 10);

    // Period 9 -> 4 mid-period.
    repeat (4) @(negedge clk);
    period = 10'd4;
    measure(5, 0, 5);

    // Back to 9 with 3/7, then drop en mid-period and re-enable.
    period = 10'd9;
    write_duty(3, 7, 2'b11);
    measure(10, 3, 7);
    repeat (4) @(negedge clk);
    en = 1'b0;
    write_duty(5, 2, 2'b11);
    @(negedge clk);
    en = 1'b1;
    measure(10, 5, 2);

    // Write landing in the wrap cycle: deferred one extra period.
    measure(10, 5, 2);
    repeat (8) @(negedge clk);
    write_duty(1, 9, 2'b11);
    measure(10, 5, 2);
    measure(10, 1, 9);

    // Full-range period.
    en = 1'b0;
    period = 10'd1023;
    write_duty(1023, 0, 2'b11);
    @(negedge clk);
    en = 1'b1;
    measure(1024, 1023, 0);

    // period = 0: every clock is a period.
    en = 1'b0;
    period = 10'd0;
    write_duty(1, 0, 2'b11);
    @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    measure(1, 1, 0);

    // Randomized run.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      duty_wr = '0;
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(19) == 0) period = W'($urandom_range(15));
      if ($urandom_range(5) == 0) begin
        duty_in = {W'($urandom_range(20)), W'($urandom_range(20))};
        duty_wr = N'($urandom_range(3));
      end
      if (c == 2000) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    duty_wr = '0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator with a programmable period and glitch-free double-buffered duty updates. All channels share one period counter. New duty and period values take effect only at a period boundary. The block sits between the control logic, which writes duties, and the output drivers. It replaces the fixed 10-bit single-channel PWM.

## Interface
Parameters:
- WIDTH, 10, counter, period and duty width in bits
- NCH, 2, number of PWM channels (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable
- period  in  WIDTH  requested period value; period length = period+1 clocks (edge mode)
- duty_in  in  NCH*WIDTH  duty values; channel i occupies bits [i*WIDTH +: WIDTH]
- duty_wr  in  NCH  per-channel write strobe into the duty shadow register
- PWM_sig  out  NCH  registered PWM outputs
- cycle_start  out  1  registered one-cycle pulse marking the first clock of each period

## Operation
- State:
  - cnt[WIDTH]
  - period_act[WIDTH]
  - duty_sh[i] and duty_act[i] per channel, each WIDTH bits
- Reset values:
  - cnt=0
  - period_act=all-ones
  - duty_sh=0 and duty_act=0
  - PWM_sig=0 and cycle_start=0
- Shadow write: when duty_wr[i]=1, duty_sh[i] takes duty_in slice i on the next edge. Writing never disturbs the running period.
- States are implied by en:
  - IDLE (en=0): cnt is held at 0.
    - period_act takes period every cycle.
    - duty_act[i] takes duty_sh[i] every cycle.
    - PWM_sig takes 0 and cycle_start takes 0.
  - RUN (en=1), edge-aligned:
    - cnt increments while cnt≠period_act.
    - At cnt==period_act (the wrap cycle), cnt returns to 0. In the same edge, period_act takes period and duty_act takes duty_sh.
- Output compare: PWM_sig[i] takes (cnt < duty_act[i]) when en=1. The compare is unsigned at full WIDTH.
  - High time per period = min(duty, period_act+1) clocks.
  - duty=0 gives a constant low output.
  - duty > period_act gives a constant high output with no glitch at the wrap.
- cycle_start: takes en & (cnt==0), so it pulses once per period.
- Simultaneous duty_wr[i] and wrap: duty_act[i] takes the old duty_sh[i] value. The new value applies from the following period.
- period=0: every cycle is a wrap. cnt stays 0, and PWM_sig[i] = (duty_act[i]≠0).
- en deasserted mid-period: on the next edge, cnt is 0 and outputs are 0. The counter state is not retained.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Timing
- Output latency: PWM_sig reflects cnt one clock later, because it is registered.
- First period after en rises:
  - The first edge with en=1 leaves cnt=0, so the first clock of RUN is the cnt=0 cycle.
  - cycle_start is high one clock later, aligned with the first PWM_sig value.
  - The first period uses the period_act and duty_act values captured during IDLE.
- Duty update latency: a value written in period N is visible from period N+1. If the write lands in the wrap cycle, it is visible from period N+2.
- No combinational path exists from any input to any output.

## Configuration
- PWM_CENTER_ALIGN_EN, when defined, selects center-aligned mode:
  - cnt counts 0→period_act, then period_act-1→1, then repeats. The period is 2*period_act clocks.
  - A direction flop is added; its reset value is up.
  - The shadow→active load and cycle_start occur at cnt==0 in the up direction only.
  - Output compare is unchanged (cnt < duty), which gives symmetric pulses of 2*duty-1 clocks for 1≤duty≤period_act.
  - period=0 holds cnt at 0.
- When undefined, the block is edge-aligned only and the direction logic is absent.

## Test plan
- Reset: hold rst_n=0 with en=1 and nonzero inputs → PWM_sig=0, cycle_start=0, no toggling. Release rst_n → counting starts at cnt=0.
- WIDTH=10, NCH=2, period=9, duty=3/7, en=1 → PWM_sig[0] high 3 of every 10 clocks and PWM_sig[1] high 7 of every 10. cycle_start pulses every 10 clocks, aligned with the rising edges.
- Boundaries: duty=0 → constant low; duty=10 with period=9 → constant high; duty=1023 with period=1023 → high 1023 of 1024 clocks; period=0 with duty=1 → constant high.
- Double-buffering:
  - Write duty 3→8 mid-period → change visible from the next period only.
  - Write in the wrap cycle → change visible one period later.
  - Change period 9→4 mid-period → the current period still lasts 10 clocks.
- en deasserted with cnt=5 → next clock PWM_sig=0 and cnt=0. Re-enable → a full period with freshly loaded duty and period.
- With PWM_CENTER_ALIGN_EN defined, period=8, duty=3 → period is 16 clocks, pulse is 5 clocks centered on cnt=0, and cycle_start pulses every 16 clocks.
